i2c_poll_seq: RTL and testbench
===============================

I2C_POLL_SEQ -- requirements
Module: i2c_poll_seq

Interface
REQ-001 SHALL take parameter NUM_CH, default 8: number of polled sensor channels, legal range 1..16.
REQ-002 SHALL take parameter ADDR_LIST, default {7'h47,7'h46,7'h45,7'h44,7'h4B,7'h4A,7'h49,7'h48}: 7*NUM_CH bits; channel k address is ADDR_LIST[7k+6:7k].
REQ-003 SHALL take parameter LUX_MASK, default 8'hF0: NUM_CH bits; bit k=1 means lux decode, bit k=0 means temperature decode.
REQ-004 SHALL take parameter GAP_CYCLES, default 16: idle cycles between complete sweeps, range 0..65535.
REQ-005 SHALL take parameter TIMEOUT_CYCLES, default 100000: watchdog limit per transaction (see REQ-024).
REQ-006 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 enable  in  1  when high, sweeps run continuously; when low, the block stops after the current transaction.
REQ-009 i2c_start  out  1  one-cycle start pulse to the I2C engine.
REQ-010 i2c_addr  out  7  slave address, held stable from start until the channel is latched.
REQ-011 i2c_rw  out  1  constant 1 (read); i2c_two_bytes  out  1  constant 1; i2c_data  out  16  constant 0.
REQ-012 i2c_ready  in  1  engine idle/done; i2c_read_data  in  16  read word; i2c_ack  in  1  slave acknowledged.
REQ-013 result  out  16*NUM_CH  per-channel decoded value; channel k is result[16k+15:16k].
REQ-014 valid  out  NUM_CH  bit k set once channel k has been latched at least once.
REQ-015 nack_err  out  NUM_CH  bit k reflects whether channel k's most recent transaction ended without ack.
REQ-016 sweep_done  out  1  one-cycle pulse after the last channel of each sweep completes.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, LATCH, GAP.
- IDLE: if enable && i2c_ready, set ch=0 and go to ISSUE.
- ISSUE: assert i2c_start for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: when i2c_ready=0, go to WAIT_DONE.
- WAIT_DONE: when i2c_ready=1, go to LATCH.
- LATCH: one cycle.
  - If ch==NUM_CH-1: pulse sweep_done, then go to GAP.
  - Otherwise: ch+=1; go to ISSUE if enable, else IDLE.
- GAP: count GAP_CYCLES, then go to IDLE.
REQ-018 In LATCH with i2c_ack=1:
- result[ch] SHALL be updated.
- valid[ch] SHALL be set.
- nack_err[ch] SHALL be cleared.
REQ-019 In LATCH with i2c_ack=0:
- result[ch] and valid[ch] SHALL be unchanged.
- nack_err[ch] SHALL be set.
REQ-020 Temperature decode:
- t9 = signed read_data[15:7], in 0.5 degC units.
- result = sign-extended t9>>>1, i.e. whole degC, range -128..127, carried in 16 bits.
REQ-021 Lux decode:
- E = read_data[15:12], F = read_data[11:0].
- lux = (F << E) / 100, computed at 28-bit width.
- Saturate to 16'hFFFF when lux exceeds 65535.
REQ-022 Latency: i2c_start SHALL rise exactly 1 cycle after entering ISSUE. Result update SHALL be visible 1 cycle after i2c_ready returns high.
REQ-023 If enable falls mid-transaction, the transaction SHALL complete and latch; the next sweep then restarts from ch=0.
REQ-024 If i2c_ready is already high in WAIT_BUSY for TIMEOUT_CYCLES, the channel SHALL be treated as a NACK (only when the macro in REQ-029 is defined).

Reset
REQ-025 While rst_n=0, all of the following SHALL be 0 and the FSM SHALL be in IDLE: result, valid, nack_err, sweep_done, i2c_start, ch, gap counter, watchdog counter.
REQ-026 Reset asserted mid-transaction SHALL abort immediately. No partial latch SHALL occur.
REQ-027 After release, the first i2c_start SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-028 Exactly one optional feature is provided: the transaction watchdog.
REQ-029 With I2C_POLL_TIMEOUT_EN defined:
- A counter SHALL run in WAIT_BUSY and WAIT_DONE.
- On reaching TIMEOUT_CYCLES, the FSM SHALL go to LATCH with the ack forced to 0.
- Without the macro, no counter SHALL exist and a hung engine stalls the FSM indefinitely.

Verification
REQ-030 Reset then enable=1, engine model acks all channels, temp word 16'h1900 on ch0 -> result[0]=16'h0019, valid[0]=1, sweep_done pulses once per 8 channels.
REQ-031 Lux channel, read_data 16'h3064 (E=3, F=100) -> result=8. Read_data 16'hFFFF -> result saturates to 16'hFFFF.
REQ-032 Temperature read_data 16'hE700 (-25 degC) -> result=16'hFFE7.
REQ-033 Engine NACKs ch5 -> nack_err[5]=1 and result[5] unchanged. Next sweep acks ch5 -> nack_err[5]=0.
REQ-034 enable dropped while ch3 is in WAIT_DONE -> ch3 latches, no further i2c_start. enable re-raised -> i2c_addr equals the ch0 address.
REQ-035 With I2C_POLL_TIMEOUT_EN and TIMEOUT_CYCLES=50, engine never drops ready -> nack_err[ch]=1 after 50 cycles and the sweep continues. rst_n pulsed low mid-transaction -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/i2c_poll_seq.sv
// Round-robin I2C sensor poller: reads NUM_CH slaves and keeps one decoded temperature/lux word per channel.
// Optional transaction watchdog is enabled by defining I2C_POLL_TIMEOUT_EN.
module i2c_poll_seq #(
  parameter int                  NUM_CH         = 8,
  parameter logic [7*NUM_CH-1:0] ADDR_LIST      = {7'h47, 7'h46, 7'h45, 7'h44, 7'h4B, 7'h4A, 7'h49, 7'h48},
  parameter logic [NUM_CH-1:0]   LUX_MASK       = 8'hF0,
  parameter int                  GAP_CYCLES     = 16,
  parameter int                  TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  i2c_start,
  output logic [6:0]            i2c_addr,
  output logic                  i2c_rw,
  output logic                  i2c_two_bytes,
  output logic [15:0]           i2c_data,
  input  logic                  i2c_ready,
  input  logic [15:0]           i2c_read_data,
  input  logic                  i2c_ack,
  output logic [16*NUM_CH-1:0]  result,
  output logic [NUM_CH-1:0]     valid,
  output logic [NUM_CH-1:0]     nack_err,
  output logic                  sweep_done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, LATCH, GAP} state_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [15:0]       gap_reg, gap_next;
  logic              start_reg, start_next;
  logic              sweep_reg, sweep_next;
  logic              timeout;
  logic              latch_fire, latch_ack;
  logic [6:0]        addr_tab [NUM_CH];
  logic [15:0]       temp_val, lux_val, dec_val;
  logic [27:0]       lux_raw, lux_quot;

  assign i2c_rw        = 1'b1;
  assign i2c_two_bytes = 1'b1;
  assign i2c_data      = 16'h0000;
  assign i2c_start     = start_reg;
  assign sweep_done    = sweep_reg;
  assign i2c_addr      = addr_tab[ch_reg];

`ifdef I2C_POLL_TIMEOUT_EN
  logic [31:0] wd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_reg <= '0;
    else if (state_reg == WAIT_BUSY || state_reg == WAIT_DONE)
      wd_reg <= wd_reg + 32'd1;
    else
      wd_reg <= '0;
  end

  assign timeout = (state_reg == WAIT_BUSY || state_reg == WAIT_DONE) &&
                   (wd_reg >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Temperature: t9 = rd[15:7] in half degrees, so t9>>>1 is simply rd[15:8] sign-extended.
  always_comb begin
    temp_val = {{8{i2c_read_data[15]}}, i2c_read_data[15:8]};
    lux_raw  = 28'(i2c_read_data[11:0]) << i2c_read_data[15:12];
    lux_quot = lux_raw / 28'd100;
    lux_val  = (lux_quot > 28'd65535) ? 16'hFFFF : lux_quot[15:0];
    dec_val  = LUX_MASK[ch_reg] ? lux_val : temp_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      gap_reg   <= '0;
      start_reg <= 1'b0;
      sweep_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      gap_reg   <= gap_next;
      start_reg <= start_next;
      sweep_reg <= sweep_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    gap_next   = gap_reg;
    start_next = 1'b0;
    sweep_next = 1'b0;
    latch_fire = 1'b0;
    latch_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && i2c_ready) begin
          ch_next    = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        start_next = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!i2c_ready) begin
          state_next = WAIT_DONE;
        end else if (timeout) begin
          latch_fire = 1'b1;
          state_next = LATCH;
        end
      end
      WAIT_DONE: begin
        // A genuine completion wins over a watchdog expiry in the same cycle.
        if (i2c_ready) begin
          latch_fire = 1'b1;
          latch_ack  = i2c_ack;
          state_next = LATCH;
        end else if (timeout) begin
          latch_fire = 1'b1;
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (ch_reg == CH_W'(NUM_CH - 1)) begin
          sweep_next = 1'b1;
          gap_next   = '0;
          state_next = GAP;
        end else begin
          ch_next    = ch_reg + 1'b1;
          state_next = enable ? ISSUE : IDLE;
        end
      end
      GAP: begin
        if ({1'b0, gap_reg} + 17'd1 >= 17'(GAP_CYCLES))
          state_next = IDLE;
        else
          gap_next = gap_reg + 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel storage is captured on the edge that enters LATCH, so it is visible one cycle after ready returns.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [15:0] res_reg;
      logic        val_reg;
      logic        nack_reg;

      assign addr_tab[gi] = ADDR_LIST[7*gi +: 7];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg  <= '0;
          val_reg  <= 1'b0;
          nack_reg <= 1'b0;
        end else if (latch_fire && ch_reg == CH_W'(gi)) begin
          if (latch_ack) begin
            res_reg  <= dec_val;
            val_reg  <= 1'b1;
            nack_reg <= 1'b0;
          end else begin
            nack_reg <= 1'b1;
          end
        end
      end

      assign result[16*gi +: 16] = res_reg;
      assign valid[gi]           = val_reg;
      assign nack_err[gi]        = nack_reg;
    end
  endgenerate

endmodule

// File: tb/tb_i2c_poll_seq.sv
// Scoreboard bench for i2c_poll_seq: a behavioural engine issues directed read words and queues the expected latch,
// a monitor compares each latch one cycle after the engine returns ready. Timeout checks need I2C_POLL_TIMEOUT_EN.
module tb_i2c_poll_seq;

  logic         clk = 1'b0;
  logic         rst_n, enable;
  logic         i2c_start, i2c_rw, i2c_two_bytes, i2c_ready, i2c_ack, sweep_done;
  logic [6:0]   i2c_addr;
  logic [15:0]  i2c_data, i2c_read_data;
  logic [127:0] result;
  logic [7:0]   valid, nack_err;

  always #5 clk = ~clk;

  i2c_poll_seq #(.NUM_CH(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_two_bytes(i2c_two_bytes), .i2c_data(i2c_data),
    .i2c_ready(i2c_ready), .i2c_read_data(i2c_read_data), .i2c_ack(i2c_ack),
    .result(result), .valid(valid), .nack_err(nack_err), .sweep_done(sweep_done)
  );

  typedef struct {
    int          ch;
    logic [15:0] res;
    logic        val;
    logic        nack;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  addr_tab [8] = '{7'h48, 7'h49, 7'h4A, 7'h4B, 7'h44, 7'h45, 7'h46, 7'h47};
  logic [15:0] tbl_data [8];
  logic        tbl_ack  [8];
  logic [15:0] tbl_exp  [8];
  logic [15:0] m_res    [8];
  logic        m_val    [8];
  logic        m_nack   [8];
  int          exp_ch    = 0;
  int          busy_ch   = 0;
  int          hang_ch   = -1;
  int          start_cnt = 0;
  int          sweep_cnt = 0;
  int          eng_c;
  logic        busy      = 1'b0;
  logic        mon_prev  = 1'b1;
  logic        sd_prev   = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_sweeps(input int n);
    int t = 0;
    while (sweep_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("sweep_count", sweep_cnt, n);
  endtask

  // Engine model: answers each start after three cycles from the directed table.
  initial begin
    i2c_ready     = 1'b1;
    i2c_read_data = 16'h0000;
    i2c_ack       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_res[i]  = 16'h0000;
      m_val[i]  = 1'b0;
      m_nack[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (rst_n && i2c_start) begin
        start_cnt++;
        check("addr_ch", 32'(i2c_addr), 32'(addr_tab[exp_ch]));
        if (exp_ch == hang_ch) begin
          m_nack[exp_ch] = 1'b1;
          exp_ch = (exp_ch + 1) % 8;
        end else begin
          busy_ch       = exp_ch;
          busy          = 1'b1;
          i2c_ready     = 1'b0;
          i2c_read_data = 16'h0000;
          repeat (3) @(negedge clk);
          eng_c = exp_ch;
          if (tbl_ack[eng_c]) begin
            m_res[eng_c]  = tbl_exp[eng_c];
            m_val[eng_c]  = 1'b1;
            m_nack[eng_c] = 1'b0;
          end else begin
            m_nack[eng_c] = 1'b1;
          end
          sb_q.push_back('{eng_c, m_res[eng_c], m_val[eng_c], m_nack[eng_c]});
          i2c_read_data = tbl_data[eng_c];
          i2c_ack       = tbl_ack[eng_c];
          i2c_ready     = 1'b1;
          busy          = 1'b0;
          exp_ch = (exp_ch + 1) % 8;
          if (!enable) exp_ch = 0;
        end
      end
    end
  end

  // Monitor: the latch must be visible one cycle after ready returns high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && i2c_ready && !mon_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          mon_e = sb_q.pop_front();
          check("result_ch", 32'(result[16*mon_e.ch +: 16]), 32'(mon_e.res));
          check("valid_ch", 32'(valid[mon_e.ch]), 32'(mon_e.val));
          check("nack_ch", 32'(nack_err[mon_e.ch]), 32'(mon_e.nack));
          $display("latch ch=%0d result=%h valid=%b nack=%b", mon_e.ch,
                   result[16*mon_e.ch +: 16], valid[mon_e.ch], nack_err[mon_e.ch]);
        end
      end
      if (rst_n && sweep_done) begin
        sweep_cnt++;
        check("sweep_done_width", 32'(sd_prev), 32'(0));
      end
      mon_prev = i2c_ready;
      sd_prev  = sweep_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  // Stimulus
  initial begin
    int edges;
    int t;
    int n;
    int sc;
    tbl_data = '{16'h1900, 16'hE700, 16'hFF80, 16'h7F80, 16'h3064, 16'hFFFF, 16'h0FFF, 16'hAFFF};
    tbl_exp  = '{16'h0019, 16'hFFE7, 16'hFFFF, 16'h007F, 16'h0008, 16'hFFFF, 16'h0028, 16'hA3CC};
    tbl_ack  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", 32'(result != 128'd0), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_nack", 32'(nack_err), 32'(0));
    check("rst_sweep_done", 32'(sweep_done), 32'(0));
    check("rst_start", 32'(i2c_start), 32'(0));
    check("rst_addr_ch0", 32'(i2c_addr), 32'(7'h48));
    check("const_rw", 32'(i2c_rw), 32'(1));
    check("const_two_bytes", 32'(i2c_two_bytes), 32'(1));
    check("const_data", 32'(i2c_data), 32'(0));

    rst_n  = 1'b1;
    enable = 1'b1;
    edges  = 0;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
      if (i2c_start) break;
    end
    check("first_start_seen", 32'(i2c_start), 32'(1));
    check("first_start_edge_ge2", 32'(edges >= 2), 32'(1));

    wait_sweeps(1);
    check("sweep1_valid", 32'(valid), 32'(8'hFF));
    check("sweep1_ch0_temp", 32'(result[15:0]), 32'(16'h0019));
    check("sweep1_nack", 32'(nack_err), 32'(0));
    tbl_data[4] = 16'h1064; tbl_exp[4] = 16'h0002;
    tbl_ack[5]  = 1'b0;

    wait_sweeps(2);
    check("nack5_set", 32'(nack_err[5]), 32'(1));
    check("nack5_result_kept", 32'(result[16*5 +: 16]), 32'(16'hFFFF));
    tbl_data[5] = 16'h3064; tbl_exp[5] = 16'h0008; tbl_ack[5] = 1'b1;

    wait_sweeps(3);
    check("nack5_clear", 32'(nack_err[5]), 32'(0));
    check("ch5_lux", 32'(result[16*5 +: 16]), 32'(16'h0008));

    // Drop enable while channel 3 is waiting on the engine.
    t = 0;
    while (!(busy && busy_ch == 3) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("ch3_busy_found", 32'(busy && busy_ch == 3), 32'(1));
    @(negedge clk);
    enable = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    sc = start_cnt;
    repeat (30) @(negedge clk);
    check("no_start_after_disable", start_cnt, sc);
    check("no_sweep_after_disable", sweep_cnt, 3);
    enable = 1'b1;
    t = 0;
    while (!i2c_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("restart_start", 32'(i2c_start), 32'(1));
    check("restart_addr_ch0", 32'(i2c_addr), 32'(7'h48));
    wait_sweeps(4);

`ifdef I2C_POLL_TIMEOUT_EN
    hang_ch = 2;
    t = 0;
    while (!(i2c_start && i2c_addr == 7'h4A) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("hang_start_found", 32'(i2c_start), 32'(1));
    n = 0;
    while (!nack_err[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 50);
    check("timeout_result_kept", 32'(result[16*2 +: 16]), 32'(16'hFFFF));
    check("timeout_valid_kept", 32'(valid[2]), 32'(1));
    hang_ch = -1;
    t = 0;
    while (!i2c_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("sweep_continues_start", 32'(i2c_start), 32'(1));
    check("sweep_continues_addr", 32'(i2c_addr), 32'(7'h4B));
    wait_sweeps(5);
`endif

    // Asynchronous reset in the middle of a transaction.
    t = 0;
    while (!busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reset_busy_found", 32'(busy), 32'(1));
    check("sb_drained", sb_q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", 32'(result != 128'd0), 32'(0));
    check("arst_valid", 32'(valid), 32'(0));
    check("arst_nack", 32'(nack_err), 32'(0));
    check("arst_sweep_done", 32'(sweep_done), 32'(0));
    check("arst_start", 32'(i2c_start), 32'(0));
    check("arst_addr_ch0", 32'(i2c_addr), 32'(7'h48));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
